// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the iterative array multiplier.
// Optional feature macro used by this slice: SEQ_MULT_SIGNED_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 2;
  localparam int STEPS     = DEF_WIDTH / DEF_DIGIT;
  localparam int CNT_W     = $clog2(STEPS + 1);

  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w_f(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_array_mult_pp_slice.sv
// DIGIT x WIDTH partial-product slice: AND-array rows summed into WIDTH+DIGIT bits.
// Built identically with or without SEQ_MULT_SIGNED_EN.
module pp_slice #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       i_a,
  input  logic [DIGIT-1:0]       i_b,
  output logic [WIDTH+DIGIT-1:0] o_pp
);

  localparam int PW = WIDTH + DIGIT;

  logic [PW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < DIGIT; j++) begin
      w_sum = w_sum + (PW'(i_a & {WIDTH{i_b[j]}}) << j);
    end
  end

  assign o_pp = w_sum;

endmodule

// File: rtl/seq_array_mult.sv
// Iterative WIDTH x WIDTH multiplier retiring DIGIT multiplier bits per cycle.
// Define SEQ_MULT_SIGNED_EN to honour tc (two's-complement operands).
module seq_array_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int NSTEP = steps_f(WIDTH, DIGIT);
  localparam int CW    = cnt_w_f(WIDTH, DIGIT);
  localparam int AW    = 2 * WIDTH;

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_param
    $error("seq_array_mult: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b_shift;
  logic [AW-1:0]          r_acc;
  logic [AW-1:0]          r_c;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_step;
  logic                   r_out_valid;
  logic [WIDTH+DIGIT-1:0] w_pp;
  logic [AW-1:0]          w_result;

  pp_slice #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pp_slice (
    .i_a  (r_a),
    .i_b  (r_b_shift[DIGIT-1:0]),
    .o_pp (w_pp)
  );

  // Step index doubles as the column offset of the current partial product.
  assign w_step = CW'(NSTEP) - r_cnt;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;

  assign w_result = r_neg ? (~r_acc + AW'(1)) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_neg <= tc && (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`else
  logic w_tc_unused;

  assign w_tc_unused = tc;
  assign w_result    = r_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == CW'(1)) w_state_nxt = DONE;
      DONE:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = r_out_valid;
  end

  assign c = r_c;

  // The first DONE cycle registers the (optionally negated) product; out_valid follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b_shift   <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
`ifdef SEQ_MULT_SIGNED_EN
            r_a       <= (tc && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
            r_b_shift <= (tc && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
`else
            r_a       <= a;
            r_b_shift <= b;
`endif
            r_acc     <= '0;
            r_cnt     <= CW'(NSTEP);
          end
        end
        BUSY: begin
          r_acc     <= r_acc + (AW'(w_pp) << (DIGIT * w_step));
          r_b_shift <= r_b_shift >> DIGIT;
          r_cnt     <= r_cnt - CW'(1);
        end
        DONE: begin
          if (!r_out_valid) begin
            r_c         <= w_result;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench for seq_array_mult: vector table, corner sequences, random ops.
module tb_seq_array_mult;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          tc;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic        ir;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        tc_i = 1'b0;
  logic        ov;
  logic        ordy = 1'b1;
  logic [31:0] c_o;

  logic        iv8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        tc8 = 1'b0;
  logic        ordy8 = 1'b1;
  logic        ir8 [3];
  logic        ov8 [3];
  logic [15:0] c8  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_array_mult #(.WIDTH(16), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv),
    .in_ready  (ir),
    .a         (a_i),
    .b         (b_i),
    .tc        (tc_i),
    .out_valid (ov),
    .out_ready (ordy),
    .c         (c_o)
  );

  for (genvar g = 0; g < 3; g++) begin : g_w8
    seq_array_mult #(.WIDTH(8), .DIGIT((g == 0) ? 1 : ((g == 1) ? 4 : 8))) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .in_ready  (ir8[g]),
      .a         (a8),
      .b         (b8),
      .tc        (tc8),
      .out_valid (ov8[g]),
      .out_ready (ordy8),
      .c         (c8[g])
    );
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer product, optionally on sign-extended operands.
  function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input bit t);
    longint      sx;
    longint      sy;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    if (t && SIGNED_EN) begin
      sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
      sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
      return 64'(sx * sy) & mask;
    end
    return (x * y) & mask;
  endfunction

  task automatic start16(input logic [15:0] x, input logic [15:0] y, input bit t, input string nm);
    a_i  = x;
    b_i  = y;
    tc_i = t;
    iv   = 1'b1;
    check({nm, " in_ready before accept"}, 64'(ir), 64'd1);
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic wait16(output int k, output bit ready_seen);
    k = 0;
    ready_seen = 1'b0;
    while (!ov && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (ir) ready_seen = 1'b1;
    end
  endtask

  task automatic do16(input logic [15:0] x, input logic [15:0] y, input bit t,
                      input logic [31:0] exp, input string nm);
    int k;
    bit rs;
    ordy = 1'b1;
    start16(x, y, t, nm);
    wait16(k, rs);
    check({nm, " latency"}, 64'(k), 64'd9);
    check({nm, " in_ready low while busy"}, 64'(rs), 64'd0);
    check({nm, " product"}, 64'(c_o), 64'(exp));
    @(posedge clk); #1;
    check({nm, " out_valid drops"}, 64'(ov), 64'd0);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input string nm);
    int  lat [3];
    bit  seen [3];
    for (int g = 0; g < 3; g++) begin
      lat[g]  = 0;
      seen[g] = 1'b0;
    end
    a8  = x;
    b8  = y;
    iv8 = 1'b1;
    check({nm, " w8 ready"}, 64'({ir8[0], ir8[1], ir8[2]}), 64'b111);
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        if (ov8[g] && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k;
          check($sformatf("%s w8 d%0d product", nm, g), 64'(c8[g]), model(8, 64'(x), 64'(y), 1'b0));
        end
      end
    end
    check({nm, " w8 latency d1"}, 64'(lat[0]), 64'd9);
    check({nm, " w8 latency d4"}, 64'(lat[1]), 64'd3);
    check({nm, " w8 latency d8"}, 64'(lat[2]), 64'd2);
  endtask

  initial begin
    vec_t        tbl [$];
    int          k;
    bit          rs;
    logic [15:0] rx;
    logic [15:0] ry;
    bit          rt;

    tbl.push_back('{16'd222,   16'd222,   1'b0, 32'd49284,      "sq222"});
    tbl.push_back('{16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE0001,   "allones"});
    tbl.push_back('{16'd0,     16'd12345, 1'b0, 32'd0,          "zero_a"});
    tbl.push_back('{16'hFFFD,  16'd5,     1'b0, 32'd327665,     "tc0_fffd"});
    tbl.push_back('{16'd1,     16'hFFFF,  1'b0, 32'h0000FFFF,   "one_x"});
`ifdef SEQ_MULT_SIGNED_EN
    tbl.push_back('{16'hFFFD,  16'd5,     1'b1, 32'hFFFFFFF1,   "s_m3x5"});
    tbl.push_back('{16'h8000,  16'h8000,  1'b1, 32'h40000000,   "s_minmin"});
    tbl.push_back('{16'h0007,  16'hFFFF,  1'b1, 32'hFFFFFFF9,   "s_7xm1"});
`else
    tbl.push_back('{16'hFFFD,  16'd5,     1'b1, 32'd327665,     "u_tc_ignored"});
    tbl.push_back('{16'h8000,  16'h8000,  1'b1, 32'h40000000,   "u_8000sq"});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(ir), 64'd1);
    check("reset out_valid", 64'(ov), 64'd0);
    check("reset c", 64'(c_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      do16(tbl[i].a, tbl[i].b, tbl[i].tc, tbl[i].exp, tbl[i].nm);
    end

    // Backpressure: result must hold and extra in_valid pulses must be ignored.
    ordy = 1'b0;
    start16(16'd77, 16'd77, 1'b0, "bp");
    wait16(k, rs);
    check("bp latency", 64'(k), 64'd9);
    for (int i = 0; i < 20; i++) begin
      a_i = 16'd1;
      b_i = 16'd1;
      iv  = i[0];
      @(posedge clk); #1;
      check("bp out_valid held", 64'(ov), 64'd1);
      check("bp c held", 64'(c_o), 64'd5929);
      check("bp in_ready low", 64'(ir), 64'd0);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    check("bp released", 64'(ov), 64'd0);
    check("bp idle after release", 64'(ir), 64'd1);

    // Reset during BUSY, then a fresh operation.
    start16(16'd76, 16'd24, 1'b0, "rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 64'(ir), 64'd1);
    check("midrst out_valid", 64'(ov), 64'd0);
    check("midrst c", 64'(c_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst no result", 64'(ov), 64'd0);
    do16(16'd76, 16'd24, 1'b0, 32'd1824, "post_rst");

    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rt = 1'($urandom);
      do16(rx, ry, rt, 32'(model(16, 64'(rx), 64'(ry), rt)), $sformatf("rnd%0d", i));
    end

    op8(8'hFF, 8'hFF, "w8_allones");
    op8(8'd0, 8'd200, "w8_zero");
    for (int i = 0; i < 8; i++) begin
      op8(8'($urandom), 8'($urandom), $sformatf("w8_rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
